// File: rtl/uram_accum_ctrl.sv
// Read-modify-write accumulator in front of a dual-port URAM.
// Port A reads the old word, port B writes {count, sum}; hazards are forwarded.
module uram_accum_ctrl #(
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [63:0]       upd_val,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              oor_err,
    output logic [ADDR_W-1:0] mem_addra,
    input  logic [71:0]       mem_douta,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              mem_web,
    output logic [71:0]       mem_dinb
);

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              drain_cnt;

    logic              p1_valid;
    logic              p1_oor;
    logic [ADDR_W-1:0] p1_addr;
    logic [63:0]       p1_val;

    logic              p2_valid;
    logic [ADDR_W-1:0] p2_addr;
    logic [71:0]       p2_data;

    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [71:0]       w_data;

    logic              accept;
    logic              in_range;
    logic [71:0]       old_word;
    logic [71:0]       new_word;
    logic [7:0]        new_cnt;

    assign accept   = upd_valid && upd_ready;
    assign in_range = 32'(upd_addr) < 32'(DEPTH);

    // P2 is the write in flight; W is the write landing on the read edge
    always_comb begin
        old_word = mem_douta;
        if (p2_valid && p2_addr == p1_addr) begin
            old_word = p2_data;
        end else if (w_valid && w_addr == p1_addr) begin
            old_word = w_data;
        end
        new_cnt  = (old_word[71:64] == 8'hFF) ? 8'hFF : old_word[71:64] + 8'd1;
        new_word = {new_cnt, old_word[63:0] + p1_val};
    end

    assign mem_addra = upd_ready ? upd_addr : '0;
    assign mem_web   = ((state == CLEAR) && !rst) || p2_valid;
    assign mem_addrb = (state == CLEAR) ? clr_addr : p2_addr;
    assign mem_dinb  = (state == CLEAR) ? '0 : p2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            drain_cnt <= 1'b0;
            upd_ready <= 1'b0;
            clr_busy  <= 1'b1;
            oor_err   <= 1'b0;
            p1_valid  <= 1'b0;
            p1_oor    <= 1'b0;
            p1_addr   <= '0;
            p1_val    <= '0;
            p2_valid  <= 1'b0;
            p2_addr   <= '0;
            p2_data   <= '0;
            w_valid   <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else begin
            p1_valid <= accept;
            p1_oor   <= !in_range;
            p1_addr  <= upd_addr;
            p1_val   <= upd_val;

            p2_valid <= p1_valid && !p1_oor;
            p2_addr  <= p1_addr;
            p2_data  <= new_word;

            w_valid  <= p2_valid;
            w_addr   <= p2_addr;
            w_data   <= p2_data;

            if (accept && !in_range) begin
                oor_err <= 1'b1;
            end

            unique case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        upd_ready <= 1'b1;
                        clr_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (clr_start) begin
                        state     <= DRAIN;
                        upd_ready <= 1'b0;
                        clr_busy  <= 1'b1;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        oor_err  <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_uram_accum_ctrl.sv
// Bench for uram_accum_ctrl: URAM model on the memory ports, write scoreboard
// on port B, and directed checks of status outputs.
module tb_uram_accum_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr;
    logic [63:0]       upd_val;
    logic              clr_start;
    logic              clr_busy;
    logic              oor_err;
    logic [ADDR_W-1:0] mem_addra;
    logic [71:0]       mem_douta;
    logic [ADDR_W-1:0] mem_addrb;
    logic              mem_web;
    logic [71:0]       mem_dinb;

    uram_accum_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_addr  (upd_addr),
        .upd_val   (upd_val),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .oor_err   (oor_err),
        .mem_addra (mem_addra),
        .mem_douta (mem_douta),
        .mem_addrb (mem_addrb),
        .mem_web   (mem_web),
        .mem_dinb  (mem_dinb)
    );

    always #5 clk = ~clk;

    // URAM: 1-cycle read latency, read returns old data on collision
    logic [71:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {8'hA5, 56'hDEAD_BEEF_0000_00, 8'(i)};
    end
    always @(posedge clk) begin
        mem_douta <= ram[mem_addra];
        if (mem_web) ram[mem_addrb] <= mem_dinb;
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [71:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic void push(input logic [7:0] a, input logic [7:0] c, input logic [63:0] s);
        wr_t e;
        e.addr = a;
        e.data = {c, s};
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor on port B
    always @(negedge clk) begin
        if (mem_web === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_addrb, mem_dinb);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 72'(mem_addrb), 72'(e.addr));
                chk("wr_data", mem_dinb, e.data);
            end
        end
    end

    task automatic upd(input logic [7:0] a, input logic [63:0] v, input logic clr);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_val   = v;
        clr_start = clr;
        @(negedge clk);
        chk("accept_ready", 72'(upd_ready), 72'd1);
        chk("mem_addra", 72'(mem_addra), 72'(a));
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s;
        logic [7:0]  c;
        logic [63:0] v;
        int          n;

        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_addr  = '0;
        upd_val   = '0;
        clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(8'(i), 8'd0, 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_upd_ready", 72'(upd_ready), 72'd0);
        chk("rst_clr_busy", 72'(clr_busy), 72'd1);
        chk("rst_oor_err", 72'(oor_err), 72'd0);
        chk("rst_mem_web", 72'(mem_web), 72'd0);
        chk("rst_mem_addra", 72'(mem_addra), 72'd0);
        chk("rst_mem_addrb", 72'(mem_addrb), 72'd0);
        chk("rst_mem_dinb", mem_dinb, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep; a clr_start here must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 4) clr_start = 1'b1;
            if (i == 5) clr_start = 1'b0;
            chk("sweep_busy", 72'(clr_busy), 72'd1);
            chk("sweep_not_ready", 72'(upd_ready), 72'd0);
        end
        @(negedge clk);
        chk("sweep_ready", 72'(upd_ready), 72'd1);
        chk("sweep_busy_low", 72'(clr_busy), 72'd0);
        idle(1);

        // Single updates with latency check
        push(8'd5, 8'd1, 64'd10);
        upd(8'd5, 64'd10, 1'b0);
        @(negedge clk);
        chk("lat_t1_no_write", 72'(mem_web), 72'd0);
        @(negedge clk);
        chk("lat_t2_write", 72'(mem_web), 72'd1);
        chk("lat_t2_addr", 72'(mem_addrb), 72'd5);
        idle(3);
        push(8'd5, 8'd2, 64'd17);
        upd(8'd5, 64'd7, 1'b0);
        idle(4);

        // Back-to-back same address (P2 path), then distance-2 (W path)
        push(8'd3, 8'd1, 64'd1);
        upd(8'd3, 64'd1, 1'b0);
        push(8'd3, 8'd2, 64'd3);
        upd(8'd3, 64'd2, 1'b0);
        push(8'd3, 8'd3, 64'd6);
        upd(8'd3, 64'd3, 1'b0);
        push(8'd3, 8'd4, 64'd10);
        upd(8'd3, 64'd4, 1'b0);
        push(8'd9, 8'd1, 64'd5);
        upd(8'd9, 64'd5, 1'b0);
        push(8'd7, 8'd1, 64'd1);
        upd(8'd7, 64'd1, 1'b0);
        push(8'd9, 8'd2, 64'd11);
        upd(8'd9, 64'd6, 1'b0);
        idle(4);

        // Sum wrap and count saturation: ends at {255, 298}
        s = '0;
        c = '0;
        for (int i = 1; i <= 300; i++) begin
            v = (i == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1;
            s = s + v;
            c = (c == 8'hFF) ? 8'hFF : c + 8'd1;
            push(8'd2, c, s);
            upd(8'd2, v, 1'b0);
        end
        idle(4);

        // Out-of-range: no write, sticky error
        upd(8'd20, 64'd3, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("oor_set", 72'(oor_err), 72'd1);
        end
        idle(1);
        push(8'd6, 8'd1, 64'd1);
        upd(8'd6, 64'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("oor_sticky", 72'(oor_err), 72'd1);
        idle(1);

        // clr_start with an update in the same cycle
        push(8'd1, 8'd1, 64'd9);
        for (int i = 0; i < DEPTH; i++) push(8'(i), 8'd0, 64'd0);
        upd(8'd1, 64'd9, 1'b1);
        @(negedge clk);
        chk("drain_not_ready", 72'(upd_ready), 72'd0);
        chk("drain_busy", 72'(clr_busy), 72'd1);
        chk("drain_oor_held", 72'(oor_err), 72'd1);
        @(negedge clk);
        chk("drain_last_write", 72'(mem_web), 72'd1);
        chk("drain_last_addr", 72'(mem_addrb), 72'd1);
        @(negedge clk);
        chk("clear_first_write", 72'(mem_web), 72'd1);
        chk("clear_first_addr", 72'(mem_addrb), 72'd0);
        chk("clear_oor_cleared", 72'(oor_err), 72'd0);
        n = 0;
        while (!upd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resweep_ready", 72'(upd_ready), 72'd1);
        chk("resweep_len", 72'(n), 72'd16);
        idle(1);
        push(8'd1, 8'd1, 64'd4);
        upd(8'd1, 64'd4, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        idle(5);
        chk("queue_empty", 72'(exp_q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
